button_ctrl: RTL and testbench
==============================

BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 Parameter DEBOUNCE_BITS, default 18, SHALL set the debounce window to 2^DEBOUNCE_BITS clk28 cycles (about 9.4 ms at 28 MHz).
REQ-002 Parameter LONG_FRAMES, default 100, SHALL set the number of frame ticks a held press needs to count as a long press (about 2 s).
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clk28  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 n_int  input  1  frame interrupt, active low, synchronous to clk28.
REQ-006 btn_n  input  1  raw magic pushbutton, active low, asynchronous and bouncing.
REQ-007 kbd_magic  input  1  keyboard magic hotkey, level, synchronous.
REQ-008 kbd_pause  input  1  keyboard pause key, level, synchronous.
REQ-009 magic_button  output  1  conditioned magic request level, consumed at the n_int falling edge.
REQ-010 pause_button  output  1  conditioned pause request level.
REQ-011 long_press  output  1  single-cycle reboot-request pulse.
REQ-012 btn_pressed  output  1  debounced button level, 1 = pressed.

Function
REQ-013 btn_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: the counter SHALL clear whenever the synchronized level equals the stable level.
REQ-015 Debounce: otherwise the counter SHALL increment, and on reaching all-ones the stable level SHALL take the synchronized level and the counter SHALL clear.
REQ-016 Debounce latency from a clean input change to btn_pressed SHALL be 2 + 2^DEBOUNCE_BITS cycles; any glitch shorter than the window SHALL be ignored.
REQ-017 frame_tick SHALL be a 1-cycle strobe asserted when registered n_int = 1 and current n_int = 0.
REQ-018 press = btn_pressed OR kbd_magic.
REQ-019 FSM states SHALL be IDLE, PRESS, LONG and WAIT_REL; the 7-bit frame counter SHALL saturate at 127.
REQ-020 IDLE: magic_button = 0; on press, go to PRESS and clear the frame counter.
REQ-021 PRESS: magic_button = 1; the frame counter SHALL increment on each frame_tick.
REQ-022 PRESS: when press = 0 and the counter is >= 2, go to IDLE, so the request is held across at least 2 frame ticks even for short presses.
REQ-023 PRESS: when press = 1 and the counter reaches LONG_FRAMES, go to LONG.
REQ-024 PRESS: if both exit conditions in REQ-022 and REQ-023 hold in the same cycle, LONG SHALL win.
REQ-025 LONG: long_press = 1 for exactly one cycle, magic_button = 0, then go unconditionally to WAIT_REL.
REQ-026 WAIT_REL: magic_button = 0; when press = 0, go to IDLE; a new press SHALL require a release first.
REQ-027 Pause: pause_button = kbd_pause OR pause_hold.
REQ-028 pause_hold SHALL set when kbd_pause = 1 and SHALL clear after 2 frame_ticks counted with kbd_pause = 0; a re-press SHALL restart that count.
REQ-029 Pause handling SHALL be independent of the FSM; magic_button and pause_button may both be 1 at once.
REQ-030 If n_int is held high so no frame_tick occurs, PRESS SHALL persist indefinitely and no timeout SHALL exist.
REQ-031 All outputs SHALL be registered, apart from the kbd_pause OR term in REQ-027.

Reset
REQ-032 While rst_n = 0: state = IDLE, stable level = released, btn_pressed = 0, magic_button = 0, pause_button = kbd_pause only, long_press = 0, all counters = 0, synchronizer flops = 1.
REQ-033 Reset asserted mid-press SHALL abort immediately with no long_press.
REQ-034 After reset release, a still-held button SHALL reach PRESS only after the full debounce window.

Verification (bench uses DEBOUNCE_BITS=4, LONG_FRAMES=5, one frame_tick every 100 cycles)
REQ-035 btn_n low for 10 cycles then high -> btn_pressed stays 0 and magic_button stays 0.
REQ-036 btn_n low held for 30 cycles -> btn_pressed rises 18 cycles after the edge.
REQ-036a Same scenario -> magic_button rises on the next cycle and stays 1 through 2 frame_ticks after release.
REQ-037 btn_n held low for 6 frames -> long_press is 1 for exactly one cycle at the 5th tick, then magic_button = 0 until release.
REQ-037a Re-press after that release -> normal PRESS entry.
REQ-038 kbd_pause pulsed for 1 cycle -> pause_button stays 1 until the 2nd following frame_tick, then drops to 0.
REQ-039 kbd_magic and kbd_pause both held, rst_n pulsed low mid-PRESS -> outputs clear asynchronously except the live kbd_pause term, and no long_press occurs.
REQ-039a After that reset releases, PRESS is re-entered one cycle later via kbd_magic.

Source files
------------

// File: rtl/button_ctrl.sv
// Magic/pause button conditioner: synchronizes and debounces the raw pushbutton,
// merges keyboard hotkeys, and stretches requests across frame interrupts.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no request; waiting for a press
// PRESS    | magic request asserted; counting frame ticks while held
// LONG     | held long enough; one-cycle reboot pulse
// WAIT_REL | request dropped; waiting for release before re-arming
module button_ctrl #(
  parameter int unsigned DEBOUNCE_BITS = 18,
  parameter int unsigned LONG_FRAMES   = 100
) (
  input  logic rst_n,
  input  logic clk28,
  input  logic n_int,
  input  logic btn_n,
  input  logic kbd_magic,
  input  logic kbd_pause,
  output logic magic_button,
  output logic pause_button,
  output logic long_press,
  output logic btn_pressed
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    LONG     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [6:0] FRAME_MAX = 7'd127;

  logic [1:0]               btn_sync;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic                     n_int_q;
  logic                     frame_tick;
  logic                     press;
  logic                     sync_pressed;
  logic                     long_hit;
  logic                     short_done;
  state_t                   state;
  logic [6:0]               frame_cnt;
  logic                     pause_hold;
  logic                     pause_ticks;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b11;
    end else begin
      btn_sync <= {btn_sync[0], btn_n};
    end
  end

  assign sync_pressed = ~btn_sync[1];

  // btn_pressed is the stable level itself; it only moves after a full window of disagreement.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt      <= '0;
      btn_pressed <= 1'b0;
    end else if (sync_pressed == btn_pressed) begin
      db_cnt <= '0;
    end else if (&db_cnt) begin
      btn_pressed <= sync_pressed;
      db_cnt      <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      n_int_q <= 1'b1;
    end else begin
      n_int_q <= n_int;
    end
  end

  assign frame_tick = n_int_q & ~n_int;
  assign press      = btn_pressed | kbd_magic;
  assign long_hit   = ({25'd0, frame_cnt} >= LONG_FRAMES);
  assign short_done = (frame_cnt >= 7'd2);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      magic_button <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      long_press <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state        <= PRESS;
            frame_cnt    <= '0;
            magic_button <= 1'b1;
          end
        end
        PRESS: begin
          if (press && long_hit) begin
            state        <= LONG;
            magic_button <= 1'b0;
            long_press   <= 1'b1;
          end else if (!press && short_done) begin
            state        <= IDLE;
            magic_button <= 1'b0;
          end else if (frame_tick && frame_cnt != FRAME_MAX) begin
            frame_cnt <= frame_cnt + 7'd1;
          end
        end
        LONG: begin
          state        <= WAIT_REL;
          magic_button <= 1'b0;
        end
        WAIT_REL: begin
          magic_button <= 1'b0;
          if (!press) begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          magic_button <= 1'b0;
        end
      endcase
    end
  end

  // Pause latch: any kbd_pause restarts the two-tick release count.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pause_hold  <= 1'b0;
      pause_ticks <= 1'b0;
    end else if (kbd_pause) begin
      pause_hold  <= 1'b1;
      pause_ticks <= 1'b0;
    end else if (pause_hold && frame_tick) begin
      if (pause_ticks) begin
        pause_hold  <= 1'b0;
        pause_ticks <= 1'b0;
      end else begin
        pause_ticks <= 1'b1;
      end
    end
  end

  assign pause_button = kbd_pause | pause_hold;

endmodule

// File: tb/tb_button_ctrl.sv
// Randomized and directed stimulus for button_ctrl, checked by a queue-based
// scoreboard against a behavioural model of the button/pause rules.
module tb_button_ctrl;

  localparam int DB_BITS  = 4;
  localparam int LFRAMES  = 5;
  localparam int FRAME_LEN = 100;
  localparam int WINDOW   = 1 << DB_BITS;

  localparam int M_REST  = 0;
  localparam int M_HELD  = 1;
  localparam int M_FIRE  = 2;
  localparam int M_LATCH = 3;

  logic clk28 = 1'b0;
  logic rst_n;
  logic n_int;
  logic btn_n;
  logic kbd_magic;
  logic kbd_pause;
  logic magic_button;
  logic pause_button;
  logic long_press;
  logic btn_pressed;

  button_ctrl #(
    .DEBOUNCE_BITS(DB_BITS),
    .LONG_FRAMES(LFRAMES)
  ) dut (
    .rst_n(rst_n),
    .clk28(clk28),
    .n_int(n_int),
    .btn_n(btn_n),
    .kbd_magic(kbd_magic),
    .kbd_pause(kbd_pause),
    .magic_button(magic_button),
    .pause_button(pause_button),
    .long_press(long_press),
    .btn_pressed(btn_pressed)
  );

  always #5 clk28 = ~clk28;

  // expected {btn_pressed, magic_button, long_press, pause_button} after each edge
  logic [3:0] sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // stimulus commands, applied at the next falling edge
  bit rst_cmd, btn_lvl, magic_cmd, pause_cmd, tick_en;
  int fcyc;

  // reference model
  bit m_s1, m_s2, m_deb, m_nprev, m_hold;
  int m_run, m_mode, m_ticks, m_ptk;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_deb = 1'b0; m_run = 0;
    m_nprev = 1'b1; m_mode = M_REST; m_ticks = 0;
    m_hold = 1'b0; m_ptk = 0;
  endtask

  task automatic model_edge();
    bit press, tick, seen;
    press = m_deb | kbd_magic;
    tick  = m_nprev & !n_int;
    m_nprev = n_int;
    // button level as seen two edges late, then flip after WINDOW straight disagreements
    seen = m_s2; m_s2 = m_s1; m_s1 = btn_lvl;
    if (seen != m_deb) begin
      m_run++;
      if (m_run == WINDOW) begin m_deb = seen; m_run = 0; end
    end else m_run = 0;
    case (m_mode)
      M_REST:  if (press) begin m_mode = M_HELD; m_ticks = 0; end
      M_HELD: begin
        if (press && m_ticks >= LFRAMES) m_mode = M_FIRE;
        else if (!press && m_ticks >= 2) m_mode = M_REST;
        else if (tick && m_ticks < 127) m_ticks++;
      end
      M_FIRE:  m_mode = M_LATCH;
      default: if (!press) m_mode = M_REST;
    endcase
    if (kbd_pause) begin m_hold = 1'b1; m_ptk = 0; end
    else if (m_hold && tick) begin
      m_ptk++;
      if (m_ptk == 2) begin m_hold = 1'b0; m_ptk = 0; end
    end
  endtask

  task automatic step();
    @(negedge clk28);
    rst_n     = rst_cmd;
    btn_n     = !btn_lvl;
    kbd_magic = magic_cmd;
    kbd_pause = pause_cmd;
    n_int     = !(tick_en && (fcyc % FRAME_LEN) < 3);
    fcyc++;
    if (!rst_n) model_reset();
    else model_edge();
    sb_q.push_back({m_deb, m_mode == M_HELD, m_mode == M_FIRE, kbd_pause | m_hold});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // monitor: compare whenever the expected or observed output vector changes
  logic [3:0] last_exp = 4'bxxxx;
  logic [3:0] last_act = 4'bxxxx;
  always @(posedge clk28) begin : mon
    logic [3:0] e, a;
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {btn_pressed, magic_button, long_press, pause_button};
      if (e !== last_exp || a !== last_act) begin
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got=%b expected=%b (btn_pressed,magic_button,long_press,pause_button)",
                   cyc, a, e);
        end
      end
      last_exp = e;
      last_act = a;
    end
  end

  initial begin
    int dur;
    rst_n = 1'b0; btn_n = 1'b1; n_int = 1'b1; kbd_magic = 1'b0; kbd_pause = 1'b0;
    rst_cmd = 1'b0; btn_lvl = 1'b0; magic_cmd = 1'b0; pause_cmd = 1'b0;
    tick_en = 1'b1; fcyc = 0;
    model_reset();
    run(5);
    rst_cmd = 1'b1;
    run(50);

    btn_lvl = 1'b1; run(10); btn_lvl = 1'b0; run(60);     // short glitch ignored
    btn_lvl = 1'b1; run(30); btn_lvl = 1'b0; run(300);    // short press, stretched request
    btn_lvl = 1'b1; run(600); btn_lvl = 1'b0; run(300);   // long press
    btn_lvl = 1'b1; run(30); btn_lvl = 1'b0; run(300);    // re-press after long
    pause_cmd = 1'b1; run(1); pause_cmd = 1'b0; run(300); // pause pulse

    // both hotkeys held, reset mid-press
    magic_cmd = 1'b1; pause_cmd = 1'b1; run(150);
    rst_cmd = 1'b0; run(3); rst_cmd = 1'b1; run(40);
    magic_cmd = 1'b0; pause_cmd = 1'b0; run(300);

    // no frame interrupts: press must persist without timeout
    tick_en = 1'b0; btn_lvl = 1'b1; run(800); btn_lvl = 1'b0; run(50);
    tick_en = 1'b1; run(300);

    for (int seg = 0; seg < 300; seg++) begin
      btn_lvl   = 1'($urandom_range(0, 1));
      magic_cmd = ($urandom_range(0, 9) == 0);
      pause_cmd = ($urandom_range(0, 7) == 0);
      dur = ($urandom_range(0, 99) < 15) ? int'($urandom_range(100, 700))
                                          : int'($urandom_range(1, 40));
      if ($urandom_range(0, 49) == 0) begin
        rst_cmd = 1'b0; run(2); rst_cmd = 1'b1;
      end
      run(dur);
    end
    btn_lvl = 1'b0; magic_cmd = 1'b0; pause_cmd = 1'b0;
    run(400);

    repeat (3) @(posedge clk28);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
